uart_cmd_rcv: RTL and testbench

Serial command receiver for the maze runner: deserialises the 8N1 UART stream on `RX`, driven by the off-board CommMaster, and assembles byte pairs into 16-bit travel-plan command words. It sits directly downstream of CommMaster on the `RX_TX` line and feeds the command processor through a `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake. Framing errors and a stalled half-command are detected and discarded so a line glitch never yields a corrupted command.

---
 rtl/maze_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 rtl/uart_cmd_rcv.sv | 93 +++++++++
 tb/tb_uart_cmd_rcv.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and defaults for the maze runner serial command path.
package maze_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  localparam int BAUD_CNT_DEF = 2604;
  localparam int TMO_BITS_DEF = 20;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: RX synchroniser, bit FSM, baud down-counter and shift register.
//   state | meaning
//   IDLE  | waiting for a falling edge on rx_s (only once rx_s has been seen high)
//   START | half-bit wait, then confirm start bit still low
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit; high -> byte_vld, low -> frm_err
module uart_rx_byte
  import maze_pkg::*;
#(
  parameter int BAUD_CNT = BAUD_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       byte_vld,
  output logic       frm_err
);

  localparam int            CW   = cnt_width(BAUD_CNT);
  localparam logic [CW-1:0] FULL = CW'(BAUD_CNT);
  localparam logic [CW-1:0] HALF = CW'(BAUD_CNT / 2);

  rx_state_t     state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [1:0]    warm_q, warm_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frm_err_q, frm_err_d;
  logic          tc;

  assign tc = (baud_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      warm_q     <= '0;
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      warm_q     <= warm_d;
      state_q    <= state_d;
      arm_q      <= arm_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Arming waits until the preset synchroniser has flushed, so a reset in the
  // middle of a frame cannot fake a start edge from the preset-1 value.
  always_comb begin
    warm_d  = {warm_q[0], 1'b1};
    state_d = state_q;
    arm_d   = arm_q;
    baud_d  = (baud_q != '0) ? baud_q - 1'b1 : baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!arm_q) begin
          arm_d = rx_s_q & warm_q[1];
        end else if (!rx_s_q) begin
          state_d = START;
          baud_d  = HALF;
          arm_d   = 1'b0;
        end
      end
      START: begin
        if (tc) begin
          if (!rx_s_q) begin
            state_d = DATA;
            baud_d  = FULL;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tc) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          baud_d  = FULL;
          if (bit_q == 4'd7) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tc) begin
          state_d = IDLE;
          arm_d   = rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    if (state_q == STOP && tc) begin
      byte_vld_d = rx_s_q;
      frm_err_d  = ~rx_s_q;
    end
  end

  assign rx_data  = shift_q;
  assign byte_vld = byte_vld_q;
  assign frm_err  = frm_err_q;

endmodule

// File: rtl/uart_cmd_rcv.sv
// Serial command receiver: pairs received bytes into 16-bit commands with a cmd_rdy handshake.
//   state   | meaning
//   WAIT_HI | expecting the high byte of a command
//   WAIT_LO | high byte held, expecting the low byte before the timeout
module uart_cmd_rcv
  import maze_pkg::*;
#(
  parameter int BAUD_CNT = BAUD_CNT_DEF,
  parameter int TMO_BITS = TMO_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int            TMO_MAX = TMO_BITS * BAUD_CNT;
  localparam int            TW      = cnt_width(TMO_MAX);
  localparam logic [TW-1:0] TMO_LIM = TW'(TMO_MAX);

  logic [7:0]  rx_data;
  logic        byte_vld;
  asm_state_t  asm_q, asm_d;
  logic [7:0]  hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        done;

  uart_rx_byte #(.BAUD_CNT(BAUD_CNT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_data),
    .byte_vld (byte_vld),
    .frm_err  (frm_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HI;
      hi_q      <= '0;
      tmo_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      hi_q      <= hi_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    asm_d = asm_q;
    hi_d  = hi_q;
    tmo_d = tmo_q;
    case (asm_q)
      WAIT_HI: begin
        if (byte_vld) begin
          asm_d = WAIT_LO;
          hi_d  = rx_data;
          tmo_d = '0;
        end
      end
      WAIT_LO: begin
        if (tmo_q != TMO_LIM) tmo_d = tmo_q + 1'b1;
        if (byte_vld) begin
          asm_d = WAIT_HI;
        end else if (frm_err || tmo_q == TMO_LIM) begin
          asm_d = WAIT_HI;
          hi_d  = '0;
        end
      end
      default: asm_d = WAIT_HI;
    endcase
  end

  // Completion outranks the consumer's clear so a fresh command is never lost.
  always_comb begin
    done      = (asm_q == WAIT_LO) && byte_vld;
    cmd_d     = done ? {hi_q, rx_data} : cmd_q;
    cmd_rdy_d = done | (cmd_rdy_q & ~clr_cmd_rdy);
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Randomised bench for uart_cmd_rcv against a byte-level command-assembly model.
module tb_uart_cmd_rcv;

  localparam int B   = 32;
  localparam int H   = B / 2;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int frm_cnt = 0;
  int rdy_drops = 0;
  logic watch_rdy = 1'b0;

  logic [15:0] m_cmd;
  logic        m_rdy;
  logic        m_pend;
  logic [7:0]  m_hi;

  uart_cmd_rcv #(.BAUD_CNT(B), .TMO_BITS(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (watch_rdy && !cmd_rdy) rdy_drops <= rdy_drops + 1;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run still active at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_cmd  = 16'h0000;
    m_rdy  = 1'b0;
    m_pend = 1'b0;
    m_hi   = 8'h00;
  endtask

  // One received frame: good bytes pair up hi/lo, a bad stop drops any held high byte.
  task automatic m_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_cmd  = {m_hi, b};
      m_rdy  = 1'b1;
      m_pend = 1'b0;
    end else begin
      m_hi   = b;
      m_pend = 1'b1;
    end
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * B) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input int per);
    logic [9:0] fr;
    fr = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (per) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send_cmd(input logic [15:0] w);
    send_byte(w[15:8], 1'b1, B);
    m_byte(w[15:8], 1'b1);
    idle_bits(1);
    send_byte(w[7:0], 1'b1, B);
    m_byte(w[7:0], 1'b1);
    idle_bits(1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_val({tag, "_cmd"}, cmd, m_cmd);
    check_val({tag, "_rdy"}, cmd_rdy, m_rdy);
  endtask

  initial begin
    int c0, rise, f0, d0, per, gap;
    logic [7:0] b;
    logic [9:0] fr;
    bit good;

    m_reset();
    repeat (3) @(negedge clk);
    check_val("rst_cmd", cmd, 16'h0000);
    check_val("rst_rdy", cmd_rdy, 1'b0);
    check_val("rst_frm", frm_err, 1'b0);
    rst_n = 1'b1;
    idle_bits(2);

    // single command with exact completion latency
    send_byte(8'h00, 1'b1, B);
    m_byte(8'h00, 1'b1);
    idle_bits(1);
    c0 = cyc;
    rise = -1;
    fork
      send_byte(8'h01, 1'b1, B);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (cmd_rdy) begin
            rise = cyc;
            break;
          end
        end
      end
    join
    m_byte(8'h01, 1'b1);
    check_val("single_latency", rise - c0, 4 + H + 9 * B);
    check_model("single");
    check_val("single_value", cmd, 16'h0001);
    pulse_clr();
    check_val("clr_rdy", cmd_rdy, 1'b0);
    idle_bits(1);

    // overwrite while cmd_rdy is held
    send_cmd(16'hA5C3);
    check_model("ovw_a");
    watch_rdy = 1'b1;
    @(negedge clk);
    d0 = rdy_drops;
    send_cmd(16'h1234);
    check_val("ovw_drops", rdy_drops - d0, 0);
    watch_rdy = 1'b0;
    check_model("ovw_b");

    // clear asserted in the completion cycle
    pulse_clr();
    check_val("pre_sim_rdy", cmd_rdy, 1'b0);
    send_byte(8'h5A, 1'b1, B);
    m_byte(8'h5A, 1'b1);
    idle_bits(1);
    fork
      send_byte(8'h6B, 1'b1, B);
      begin
        repeat (3 + H + 9 * B) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    m_byte(8'h6B, 1'b1);
    check_model("setclr");

    // timeout discards a lone high byte
    send_byte(8'hFF, 1'b1, B);
    m_byte(8'hFF, 1'b1);
    idle_bits(25);
    m_pend = 1'b0;
    send_cmd(16'h0203);
    check_model("timeout");

    // framing error on the high byte
    f0 = frm_cnt;
    send_byte(8'h3C, 1'b0, B);
    m_byte(8'h3C, 1'b0);
    idle_bits(2);
    check_val("frm_pulse", frm_cnt - f0, 1);
    check_model("frm_hold");
    send_cmd(16'h0011);
    check_model("frm_after");

    // sub-half-bit glitch on idle line
    f0 = frm_cnt;
    RX = 1'b0;
    repeat ((B * 3) / 10) @(negedge clk);
    idle_bits(3);
    check_val("glitch_frm", frm_cnt - f0, 0);
    check_model("glitch");
    send_cmd(16'h9876);
    check_model("glitch_after");

    // reset during bit 4 of a low byte
    send_byte(8'h77, 1'b1, B);
    m_byte(8'h77, 1'b1);
    idle_bits(1);
    fr = {1'b1, 8'h05, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      if (i == 5) begin
        repeat (H) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_cmd", cmd, 16'h0000);
        check_val("midrst_rdy", cmd_rdy, 1'b0);
        check_val("midrst_frm", frm_err, 1'b0);
        rst_n = 1'b1;
        m_reset();
        repeat (B - H - 3) @(negedge clk);
      end else begin
        repeat (B) @(negedge clk);
      end
    end
    f0 = frm_cnt;
    idle_bits(2);
    check_model("midrst_idle");
    send_cmd(16'h4321);
    check_val("midrst_frm_cnt", frm_cnt - f0, 0);
    check_model("midrst_after");

    // randomised frames, gaps, baud skew and clears
    for (int n = 0; n < 40; n++) begin
      per  = B - 1 + $urandom_range(0, 2);
      b    = 8'($urandom);
      good = ($urandom_range(0, 9) != 0);
      send_byte(b, good, per);
      m_byte(b, good);
      if ($urandom_range(0, 19) == 0) begin
        gap = 25;
        m_pend = 1'b0;
      end else begin
        gap = $urandom_range(good ? 0 : 1, 2);
      end
      idle_bits(gap);
      check_model("rand");
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
